// File: rtl/pc_stack.sv
// pc_stack: fetch-stage program counter with PC-relative branch, stall,
// and a DEPTH-entry return-address stack with sticky overflow/underflow flags.
module pc_stack #(
  parameter int unsigned   D          = 10,
  parameter int unsigned   OFFW       = 8,
  parameter int unsigned   DEPTH      = 4,
  parameter logic [D-1:0]  RESET_ADDR = '0
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         start,
  input  logic                         stall,
  input  logic                         jumpEn,
  input  logic [D-1:0]                 target,
  input  logic                         branchEn,
  input  logic                         branchTaken,
  input  logic [OFFW-1:0]              offset,
  input  logic                         callEn,
  input  logic                         retEn,
  output logic [D-1:0]                 programCounter,
  output logic [$clog2(DEPTH+1)-1:0]   stackDepth,
  output logic                         stackOverflow,
  output logic                         stackUnderflow
);

  localparam int unsigned DW = $clog2(DEPTH + 1);
  localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [D-1:0]  pc_q, pc_d;
  logic [DW-1:0] depth_q, depth_d;
  logic          ovf_q, ovf_d;
  logic          unf_q, unf_d;
  logic          push;
  logic [D-1:0]  pc_inc;
  logic [D-1:0]  pc_br;
  logic [AW-1:0] push_idx;
  logic [AW-1:0] pop_idx;
  logic          stack_full;
  logic          stack_empty;

  logic [D-1:0]  stack_mem [DEPTH];

  assign programCounter = pc_q;
  assign stackDepth     = depth_q;
  assign stackOverflow  = ovf_q;
  assign stackUnderflow = unf_q;

  // Next-state selection: requests resolved strictly by priority.
  always_comb begin
    pc_d        = pc_q;
    depth_d     = depth_q;
    ovf_d       = ovf_q;
    unf_d       = unf_q;
    push        = 1'b0;
    pc_inc      = pc_q + D'(1);
    pc_br       = pc_q + D'($signed(offset));
    push_idx    = AW'(depth_q);
    pop_idx     = AW'(depth_q - DW'(1));
    stack_full  = (depth_q == DW'(DEPTH));
    stack_empty = (depth_q == '0);

    if (start) begin
      pc_d    = RESET_ADDR;
      depth_d = '0;
      ovf_d   = 1'b0;
      unf_d   = 1'b0;
    end else if (stall) begin
      pc_d = pc_q;
    end else if (retEn) begin
      if (!stack_empty) begin
        pc_d    = stack_mem[pop_idx];
        depth_d = depth_q - DW'(1);
      end else begin
        pc_d  = pc_inc;
        unf_d = 1'b1;
      end
    end else if (callEn) begin
      pc_d = target;
      if (!stack_full) begin
        push    = 1'b1;
        depth_d = depth_q + DW'(1);
      end else begin
        ovf_d = 1'b1;
      end
    end else if (jumpEn) begin
      pc_d = target;
    end else if (branchEn && branchTaken) begin
      pc_d = pc_br;
    end else begin
      pc_d = pc_inc;
    end
  end

  // Architectural state register with asynchronous active-low reset.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pc_q    <= RESET_ADDR;
      depth_q <= '0;
      ovf_q   <= 1'b0;
      unf_q   <= 1'b0;
    end else begin
      pc_q    <= pc_d;
      depth_q <= depth_d;
      ovf_q   <= ovf_d;
      unf_q   <= unf_d;
    end
  end

  // Return-address storage; contents are not cleared by reset, only the depth is.
  always_ff @(posedge clk) begin
    if (reset && push) begin
      stack_mem[push_idx] <= pc_inc;
    end
  end

endmodule

// File: tb/tb_pc_stack.sv
// tb_pc_stack: directed plus randomized checks of pc_stack against a
// queue-based behavioural model of the program counter and return stack.
module tb_pc_stack;

  localparam int D     = 10;
  localparam int OFFW  = 8;
  localparam int DEPTH = 4;
  localparam int MASK  = (1 << D) - 1;

  logic          clk;
  logic          reset;
  logic          start;
  logic          stall;
  logic          jumpEn;
  logic [D-1:0]  target;
  logic          branchEn;
  logic          branchTaken;
  logic [OFFW-1:0] offset;
  logic          callEn;
  logic          retEn;
  logic [D-1:0]  programCounter;
  logic [2:0]    stackDepth;
  logic          stackOverflow;
  logic          stackUnderflow;

  int n_checks = 0;
  int n_pass   = 0;

  // Reference model state
  int m_pc;
  int m_q[$];
  bit m_ovf;
  bit m_unf;

  pc_stack #(
    .D(D),
    .OFFW(OFFW),
    .DEPTH(DEPTH),
    .RESET_ADDR('0)
  ) dut (
    .clk(clk),
    .reset(reset),
    .start(start),
    .stall(stall),
    .jumpEn(jumpEn),
    .target(target),
    .branchEn(branchEn),
    .branchTaken(branchTaken),
    .offset(offset),
    .callEn(callEn),
    .retEn(retEn),
    .programCounter(programCounter),
    .stackDepth(stackDepth),
    .stackOverflow(stackOverflow),
    .stackUnderflow(stackUnderflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
  endtask

  task automatic model_reset();
    m_pc  = 0;
    m_q.delete();
    m_ovf = 1'b0;
    m_unf = 1'b0;
  endtask

  task automatic model_update();
    int off;
    if (start) begin
      model_reset();
    end else if (stall) begin
      // nothing changes
    end else if (retEn) begin
      if (m_q.size() > 0) m_pc = m_q.pop_back();
      else begin
        m_pc  = (m_pc + 1) & MASK;
        m_unf = 1'b1;
      end
    end else if (callEn) begin
      if (m_q.size() < DEPTH) m_q.push_back((m_pc + 1) & MASK);
      else m_ovf = 1'b1;
      m_pc = int'(target);
    end else if (jumpEn) begin
      m_pc = int'(target);
    end else if (branchEn && branchTaken) begin
      off  = int'($signed(offset));
      m_pc = (m_pc + off) & MASK;
    end else begin
      m_pc = (m_pc + 1) & MASK;
    end
  endtask

  task automatic check_model(input string tag);
    check({tag, ".pc"},    32'(programCounter), 32'(m_pc));
    check({tag, ".depth"}, 32'(stackDepth),     32'(m_q.size()));
    check({tag, ".ovf"},   32'(stackOverflow),  32'(m_ovf));
    check({tag, ".unf"},   32'(stackUnderflow), 32'(m_unf));
  endtask

  task automatic clear_req();
    start = 0; stall = 0; jumpEn = 0; branchEn = 0; branchTaken = 0;
    callEn = 0; retEn = 0; target = '0; offset = '0;
  endtask

  // Apply the currently driven requests for one clock and compare with the model.
  task automatic tick(input string tag);
    @(posedge clk);
    #1;
    model_update();
    check_model(tag);
    clear_req();
  endtask

  task automatic idle(input string tag);
    clear_req();
    tick(tag);
  endtask

  task automatic do_jump(input string tag, input logic [D-1:0] t);
    clear_req(); jumpEn = 1; target = t; tick(tag);
  endtask

  task automatic do_call(input string tag, input logic [D-1:0] t);
    clear_req(); callEn = 1; target = t; tick(tag);
  endtask

  task automatic do_ret(input string tag);
    clear_req(); retEn = 1; tick(tag);
  endtask

  task automatic do_branch(input string tag, input logic taken, input logic [OFFW-1:0] o);
    clear_req(); branchEn = 1; branchTaken = taken; offset = o; tick(tag);
  endtask

  task automatic async_reset_pulse(input string tag);
    #2 reset = 1'b0;
    #1;
    model_reset();
    check_model(tag);
    #2 reset = 1'b1;
  endtask

  initial begin
    int r;
    clear_req();
    model_reset();
    reset = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check_model("reset");
    reset = 1'b1;

    // Test 1: async reset mid-run from PC=0x155, depth=2
    do_call("t1.call0", 10'h100);
    do_call("t1.call1", 10'h154);
    idle("t1.idle");
    check("t1.pc155", 32'(programCounter), 32'h155);
    check("t1.depth2", 32'(stackDepth), 32'd2);
    async_reset_pulse("t1.async");
    check("t1.pc0", 32'(programCounter), 32'h0);
    idle("t1.r1"); check("t1.pc1", 32'(programCounter), 32'h1);
    idle("t1.r2"); check("t1.pc2", 32'(programCounter), 32'h2);
    idle("t1.r3"); check("t1.pc3", 32'(programCounter), 32'h3);

    // Test 2: wrap and branching
    do_jump("t2.j3ff", 10'h3FF);
    idle("t2.wrap"); check("t2.pc000", 32'(programCounter), 32'h000);
    do_jump("t2.j5", 10'h005);
    do_branch("t2.brneg", 1'b1, 8'hF8); check("t2.pc3fd", 32'(programCounter), 32'h3FD);
    do_jump("t2.j5b", 10'h005);
    do_branch("t2.brnt", 1'b0, 8'hF8); check("t2.pc006", 32'(programCounter), 32'h006);

    // Test 3: single call/return
    do_jump("t3.j10", 10'h010);
    do_call("t3.call", 10'h100);
    check("t3.pc100", 32'(programCounter), 32'h100);
    check("t3.d1", 32'(stackDepth), 32'd1);
    do_ret("t3.ret");
    check("t3.pc011", 32'(programCounter), 32'h011);
    check("t3.d0", 32'(stackDepth), 32'd0);

    // Test 4: overflow then LIFO unwind and underflow
    do_call("t4.c1", 10'h020);
    do_call("t4.c2", 10'h040);
    do_call("t4.c3", 10'h060);
    do_call("t4.c4", 10'h080);
    check("t4.noovf", 32'(stackOverflow), 32'd0);
    do_call("t4.c5", 10'h0A0);
    check("t4.ovf", 32'(stackOverflow), 32'd1);
    check("t4.d4", 32'(stackDepth), 32'd4);
    do_ret("t4.r1"); check("t4.pop61", 32'(programCounter), 32'h061);
    do_ret("t4.r2"); check("t4.pop41", 32'(programCounter), 32'h041);
    do_ret("t4.r3"); check("t4.pop21", 32'(programCounter), 32'h021);
    do_ret("t4.r4"); check("t4.pop12", 32'(programCounter), 32'h012);
    do_ret("t4.r5");
    check("t4.pc13", 32'(programCounter), 32'h013);
    check("t4.unf", 32'(stackUnderflow), 32'd1);

    // Test 5: stall dominance, then ret beats call/jump
    clear_req(); stall = 1; retEn = 1; callEn = 1; jumpEn = 1; target = 10'h2BC;
    tick("t5.stall");
    check("t5.pchold", 32'(programCounter), 32'h013);
    do_call("t5.c", 10'h1F0);
    clear_req(); retEn = 1; callEn = 1; jumpEn = 1; target = 10'h3AA;
    tick("t5.combo");
    check("t5.pop", 32'(programCounter), 32'h014);
    check("t5.d0", 32'(stackDepth), 32'd0);

    // Test 6: sync start clears everything
    do_call("t6.c1", 10'h100);
    do_call("t6.c2", 10'h200);
    do_call("t6.c3", 10'h2A0);
    check("t6.pc2a0", 32'(programCounter), 32'h2A0);
    check("t6.d3", 32'(stackDepth), 32'd3);
    check("t6.ovfset", 32'(stackOverflow), 32'd1);
    clear_req(); start = 1; callEn = 1; target = 10'h111;
    tick("t6.start");
    check("t6.pc0", 32'(programCounter), 32'h000);
    check("t6.flags", 32'({stackOverflow, stackUnderflow}), 32'd0);

    // Randomized traffic against the model
    for (int i = 0; i < 400; i++) begin
      clear_req();
      r = $urandom_range(0, 99);
      target = D'($urandom);
      offset = OFFW'($urandom);
      if (r < 2)       start = 1;
      else if (r < 10) stall = 1;
      else if (r < 30) retEn = 1;
      else if (r < 52) callEn = 1;
      else if (r < 62) jumpEn = 1;
      else if (r < 82) begin branchEn = 1; branchTaken = 1'($urandom); end
      // Pile extra lower-priority requests on top to exercise priority.
      if ($urandom_range(0, 3) == 0) begin
        jumpEn = 1; branchEn = 1; branchTaken = 1;
      end
      tick("rand");
      if ($urandom_range(0, 99) == 0) async_reset_pulse("rand.async");
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
